derr_store: RTL and testbench

- Storage stage directly downstream of the UV DC error-diffusion quantizer.
- Captures the 6-byte `derr` result of each macroblock.
- Keeps the left-neighbour error word in a register.
- Keeps one top-neighbour error word per macroblock column in a line memory.
- Serves both words back to the quantizer for the next macroblock (left) and the next row (top, via its `top_derr_en`/`top_derr_addr` read port).

---
 rtl/derr_store_pkg.sv | 22 ++
 rtl/derr_line_ram.sv | 25 ++
 rtl/derr_store.sv | 129 ++++++++++++
 tb/tb_derr_store.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/derr_store_pkg.sv
// Shared constants for the UV DC error storage stage: default widths, byte-lane
// indices into the 6-byte derr word, and the clear/ready FSM encoding.
package derr_store_pkg;

  localparam int ERR_W  = 8;
  localparam int ADDR_W = 10;

  // Byte lanes of wr_derr = {v3,v2,v1,u3,u2,u1}
  localparam int U1 = 0;
  localparam int U2 = 1;
  localparam int U3 = 2;
  localparam int V1 = 3;
  localparam int V2 = 4;
  localparam int V3 = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } state_t;

endpackage

// File: rtl/derr_line_ram.sv
// Top-neighbour line memory: one write port, one registered read port.
// Output register has no reset and only loads on re, so it holds between reads.
module derr_line_ram #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DW-1:0]     rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Read-first block RAM: a same-cycle read sees the old contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/derr_store.sv
// derr_store: captures the quantizer's 6-byte derr result per macroblock, keeps
// the left-neighbour word in a register and the top-neighbour word per column
// in a line memory that is zeroed at every frame start.
// Build option: DERR_FWD_EN selects write-first forwarding for a same-column
// read and write in one cycle; without it the read returns the old contents.
module derr_store import derr_store_pkg::*; #(
  parameter int ADDR_W = derr_store_pkg::ADDR_W,
  parameter int DEPTH  = 1024,
  parameter int ERR_W  = derr_store_pkg::ERR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_start,
  input  logic [ADDR_W-1:0]   mb_w,
  input  logic                wr_valid,
  input  logic [ADDR_W-1:0]   wr_x,
  input  logic [6*ERR_W-1:0]  wr_derr,
  input  logic                top_derr_en,
  input  logic [ADDR_W-1:0]   top_derr_addr,
  output logic [4*ERR_W-1:0]  top_derr,
  output logic [4*ERR_W-1:0]  left_derr,
  output logic                busy,
  output logic                addr_err
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [ADDR_W-1:0]   mb_w_reg;
  logic [ADDR_W-1:0]   last_col;
  logic [4*ERR_W-1:0]  wr_top, wr_left;
  logic                wr_fire, clr_fire, rd_oob;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [4*ERR_W-1:0]  ram_wdata, ram_q;
  logic                rd_zero_q;

  assign wr_top  = {wr_derr[V3*ERR_W +: ERR_W], wr_derr[V2*ERR_W +: ERR_W],
                    wr_derr[U3*ERR_W +: ERR_W], wr_derr[U2*ERR_W +: ERR_W]};
  assign wr_left = {wr_derr[V3*ERR_W +: ERR_W], wr_derr[V1*ERR_W +: ERR_W],
                    wr_derr[U3*ERR_W +: ERR_W], wr_derr[U1*ERR_W +: ERR_W]};

  assign last_col = mb_w_reg - ONE;
  assign rd_oob   = top_derr_addr >= mb_w_reg;
  // A frame_start in READY wins over a coincident result write
  assign wr_fire  = (state == ST_READY) && wr_valid && !frame_start && (wr_x < mb_w_reg);
  assign clr_fire = (state == ST_CLEAR);

  assign ram_we    = clr_fire || wr_fire;
  assign ram_waddr = clr_fire ? clr_cnt : wr_x;
  assign ram_wdata = clr_fire ? '0 : wr_top;

  derr_line_ram #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DW(4*ERR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (top_derr_en),
    .raddr (top_derr_addr),
    .rdata (ram_q)
  );

  // Clear/ready FSM with clear counter, left-neighbour register and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      clr_cnt   <= '0;
      mb_w_reg  <= '0;
      busy      <= 1'b0;
      left_derr <= '0;
      addr_err  <= 1'b0;
    end else if (frame_start) begin
      mb_w_reg  <= mb_w;
      clr_cnt   <= '0;
      left_derr <= '0;
      addr_err  <= 1'b0;
      state     <= (mb_w == '0) ? ST_READY : ST_CLEAR;
      busy      <= (mb_w != '0);
    end else begin
      if (top_derr_en && rd_oob) addr_err <= 1'b1;
      case (state)
        ST_CLEAR: begin
          if (clr_cnt == last_col) begin
            state <= ST_READY;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + ONE;
          end
        end
        ST_READY: begin
          if (wr_valid) begin
            if (wr_x >= mb_w_reg) addr_err  <= 1'b1;
            else if (wr_x == last_col) left_derr <= '0;
            else left_derr <= wr_left;
          end
        end
        default: ;
      endcase
    end
  end

  // Read qualifier: out-of-range or not-ready reads return zero; reset reads as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_zero_q <= 1'b1;
    else if (top_derr_en) rd_zero_q <= (state != ST_READY) || rd_oob;
  end

`ifdef DERR_FWD_EN
  logic               fwd_q;
  logic [4*ERR_W-1:0] fwd_word_q;

  // Capture the word being written when the read hits the same column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_word_q <= '0;
    end else if (top_derr_en) begin
      fwd_q      <= wr_fire && (wr_x == top_derr_addr);
      fwd_word_q <= wr_top;
    end
  end

  assign top_derr = rd_zero_q ? '0 : (fwd_q ? fwd_word_q : ram_q);
`else
  assign top_derr = rd_zero_q ? '0 : ram_q;
`endif

endmodule

// File: tb/tb_derr_store.sv
// Directed self-checking bench for derr_store (mb_w = 4 frames, write/read,
// row end, same-cycle collision, out-of-range, reset mid-clear).
module tb_derr_store;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic [9:0]  mb_w;
  logic        wr_valid;
  logic [9:0]  wr_x;
  logic [47:0] wr_derr;
  logic        top_derr_en;
  logic [9:0]  top_derr_addr;
  logic [31:0] top_derr;
  logic [31:0] left_derr;
  logic        busy;
  logic        addr_err;

  int n_chk  = 0;
  int n_fail = 0;

  derr_store dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .mb_w          (mb_w),
    .wr_valid      (wr_valid),
    .wr_x          (wr_x),
    .wr_derr       (wr_derr),
    .top_derr_en   (top_derr_en),
    .top_derr_addr (top_derr_addr),
    .top_derr      (top_derr),
    .left_derr     (left_derr),
    .busy          (busy),
    .addr_err      (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a frame and measure how many cycles busy stays high after it
  task automatic frame(input logic [9:0] w, input int exp_busy);
    int n;
    frame_start = 1'b1;
    mb_w        = w;
    tick();
    frame_start = 1'b0;
    chk("left_zero_on_frame", left_derr, 0);
    chk("addr_err_clr_on_frame", addr_err, 0);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk("busy_len", n, exp_busy);
  endtask

  task automatic wr(input logic [9:0] x, input logic [47:0] d);
    wr_valid = 1'b1;
    wr_x     = x;
    wr_derr  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
    top_derr_en   = 1'b1;
    top_derr_addr = a;
    tick();
    top_derr_en   = 1'b0;
    chk(tag, top_derr, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, want done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_col;
    rst_n = 1'b0; frame_start = 1'b0; mb_w = '0; wr_valid = 1'b0; wr_x = '0;
    wr_derr = '0; top_derr_en = 1'b0; top_derr_addr = '0;
    tick(); tick();
    chk("rst_top", top_derr, 0);
    chk("rst_left", left_derr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_err", addr_err, 0);
    rst_n = 1'b1;
    tick();

    // 1: clear 4 columns
    frame(10'd4, 4);
    for (int i = 0; i < 4; i++) rd("clr_read", 10'(i), 32'h0);
    chk("t1_left", left_derr, 0);
    chk("t1_addr_err", addr_err, 0);

    // 2: write col 1, left and top packing
    wr(10'd1, 48'h06_05_04_03_02_01);
    chk("t2_left", left_derr, 32'h06040301);
    rd("t2_top", 10'd1, 32'h06050302);
    tick(); tick();
    chk("t2_top_hold", top_derr, 32'h06050302);

    // 3: row-end write zeroes left
    wr(10'd3, 48'h0A_0B_0C_0D_0E_0F);
    chk("t3_left_row_end", left_derr, 0);
    rd("t3_top", 10'd3, 32'h0A0B0D0E);

    // 4: same-cycle write/read at col 2
    wr(10'd2, 48'h11_11_11_11_11_11);
    chk("t4_left_old", left_derr, 32'h11111111);
    wr_valid = 1'b1; wr_x = 10'd2; wr_derr = 48'h7F_7F_00_80_80_00;
    top_derr_en = 1'b1; top_derr_addr = 10'd2;
    tick();
    wr_valid = 1'b0; top_derr_en = 1'b0;
`ifdef DERR_FWD_EN
    exp_col = 32'h7F7F8080;
`else
    exp_col = 32'h11111111;
`endif
    chk("t4_collide", top_derr, exp_col);
    chk("t4_left_new", left_derr, 32'h7F008000);
    rd("t4_after", 10'd2, 32'h7F7F8080);
    chk("t4_addr_err", addr_err, 0);

    // 5: out-of-range write and read
    wr(10'd5, 48'hFF_FF_FF_FF_FF_FF);
    chk("t5_addr_err", addr_err, 1);
    chk("t5_left_hold", left_derr, 32'h7F008000);
    rd("t5_mem1", 10'd1, 32'h06050302);
    rd("t5_mem3", 10'd3, 32'h0A0B0D0E);
    rd("t5_oob_read", 10'd6, 32'h0);
    chk("t5_addr_err_sticky", addr_err, 1);
    frame(10'd4, 4);
    rd("t5_cleared", 10'd1, 32'h0);
    rd("t5_oob_read2", 10'd4, 32'h0);
    chk("t5_read_oob_err", addr_err, 1);

    // 6: reset in the middle of a clear
    wr(10'd1, 48'h06_05_04_03_02_01);
    rd("t6_pre", 10'd1, 32'h06050302);
    chk("t6_left_pre", left_derr, 32'h06040301);
    frame_start = 1'b1; mb_w = 10'd8;
    tick();
    frame_start = 1'b0;
    chk("t6_busy", busy, 1);
    chk("t6_left_frame", left_derr, 0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_top", top_derr, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr_err", addr_err, 0);
    chk("t6_rst_left", left_derr, 0);
    tick();
    rst_n = 1'b1;
    wr(10'd1, 48'h06_05_04_03_02_01);
    chk("t6_idle_wr_left", left_derr, 0);
    chk("t6_idle_wr_err", addr_err, 0);
    chk("t6_idle_busy", busy, 0);
    frame(10'd4, 4);
    rd("t6_after", 10'd1, 32'h0);

    // zero-width frame goes straight to ready, everything out of range
    frame(10'd0, 0);
    wr(10'd0, 48'h01_01_01_01_01_01);
    chk("mbw0_err", addr_err, 1);
    chk("mbw0_left", left_derr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
